// File: rtl/pixel_stream_pkg.sv
// Shared types and helpers for the test-pattern word stream generator.
// Host values are little-endian on the wire, so every emitted word is byte-swapped.
package pixel_stream_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StPixels,
        StCsumLo,
        StCsumHi,
        StPad
    } streamState_e;

    localparam logic [16:0] FletcherMod = 17'd65535;

    function automatic logic [15:0] byteSwap(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    // One conditional subtract suffices: both addends are below 2^16.
    function automatic logic [15:0] modReduce(input logic [16:0] sum);
        logic [16:0] r;
        r = (sum >= FletcherMod) ? (sum - FletcherMod) : sum;
        return r[15:0];
    endfunction

endpackage

// File: rtl/fletcher32_acc.sv
// Fletcher-32 running sums over 16-bit words; s1/s2 are kept reduced modulo 65535.
// clr together with en restarts the sums with din as the first word.
module fletcher32_acc
    import pixel_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [31:0] dout
);

    logic [15:0] s1Q, s2Q;
    logic [15:0] s1Base, s2Base;
    logic [15:0] s1Next, s2Next;
    logic [16:0] sum1, sum2;

    always_comb begin
        s1Base = clr ? 16'h0000 : s1Q;
        s2Base = clr ? 16'h0000 : s2Q;
        sum1   = {1'b0, s1Base} + {1'b0, din};
        s1Next = modReduce(sum1);
        sum2   = {1'b0, s2Base} + {1'b0, s1Next};
        s2Next = modReduce(sum2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Q <= 16'h0000;
            s2Q <= 16'h0000;
        end else if (en) begin
            s1Q <= s1Next;
            s2Q <= s2Next;
        end else if (clr) begin
            s1Q <= 16'h0000;
            s2Q <= 16'h0000;
        end
    end

    assign dout = {s2Q, s1Q};

endmodule

// File: rtl/pixel_stream_gen.sv
// Test-pattern frame transmitter: header words, ramp pixels, Fletcher-32 checksum, zero pad.
// Output is a registered word; the next word is computed combinationally and loaded on advance.
module pixel_stream_gen
    import pixel_stream_pkg::*;
#(
    parameter int unsigned DimWidth       = 12,
    parameter int unsigned HeaderIdxWidth = 4,
    parameter int unsigned PadWidth       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [HeaderIdxWidth-1:0] cfg_header_count,
    input  logic [DimWidth-1:0]       cfg_width,
    input  logic [DimWidth-1:0]       cfg_height,
    input  logic [PadWidth-1:0]       cfg_padding,
    input  logic [15:0]               cfg_pixel_initial,
    input  logic [15:0]               cfg_pixel_delta,
    output logic [HeaderIdxWidth-1:0] hdr_idx,
    input  logic [15:0]               hdr_word,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               out_data,
    output logic                      busy,
    output logic                      done
);

    streamState_e state, nxtState;

    logic [HeaderIdxWidth-1:0] hdrIdx, nxtHdrIdx, cfgHdrCount, effHdrCount;
    logic [DimWidth-1:0]       col, row, nxtCol, nxtRow;
    logic [DimWidth-1:0]       cfgWidth, cfgHeight, effWidth, effHeight;
    logic [PadWidth-1:0]       padCnt, nxtPadCnt, cfgPadding;
    logic [15:0]               cfgInit, cfgDelta, effInit;
    logic [15:0]               pixel, pixStep, nxtPixel, nxtValue;
    logic [15:0]               outData;
    logic                      outValid, doneQ;
    logic                      startAccept, handshake, advance, lastPixel;
    logic                      deltaPos, deltaNeg;
    logic                      accClr, accEn;
    logic [31:0]               accOut;

    // In idle the frame is defined by the live cfg inputs; afterwards by the latched copy.
    always_comb begin
        effHdrCount = (state == StIdle) ? cfg_header_count  : cfgHdrCount;
        effWidth    = (state == StIdle) ? cfg_width         : cfgWidth;
        effHeight   = (state == StIdle) ? cfg_height        : cfgHeight;
        effInit     = (state == StIdle) ? cfg_pixel_initial : cfgInit;
    end

    always_comb begin
        startAccept = (state == StIdle) && start;
        handshake   = outValid && out_ready;
        advance     = startAccept || handshake;
        lastPixel   = (col == effWidth - DimWidth'(1)) && (row == effHeight - DimWidth'(1));
        deltaPos    = !cfgDelta[15] && (cfgDelta != 16'h0000);
        deltaNeg    = cfgDelta[15];
        if ((deltaPos && pixel == 16'hFFFF) || (deltaNeg && pixel == 16'h0000)) begin
            pixStep = cfgInit;
        end else begin
            pixStep = pixel + cfgDelta;
        end
    end

    always_comb begin
        nxtState  = state;
        nxtValue  = 16'h0000;
        nxtHdrIdx = hdrIdx;
        nxtCol    = col;
        nxtRow    = row;
        nxtPadCnt = padCnt;
        nxtPixel  = pixel;
        unique case (state)
            StIdle, StHeader: begin
                if (hdrIdx < effHdrCount) begin
                    nxtState  = StHeader;
                    nxtValue  = hdr_word;
                    nxtHdrIdx = hdrIdx + HeaderIdxWidth'(1);
                end else if (effWidth != '0 && effHeight != '0) begin
                    nxtState = StPixels;
                    nxtValue = effInit;
                    nxtPixel = effInit;
                    nxtCol   = '0;
                    nxtRow   = '0;
                end else begin
                    nxtState = StCsumLo;
                    nxtValue = accOut[15:0];
                end
            end
            StPixels: begin
                if (!lastPixel) begin
                    nxtState = StPixels;
                    nxtValue = pixStep;
                    nxtPixel = pixStep;
                    if (col == effWidth - DimWidth'(1)) begin
                        nxtCol = '0;
                        nxtRow = row + DimWidth'(1);
                    end else begin
                        nxtCol = col + DimWidth'(1);
                    end
                end else begin
                    nxtState = StCsumLo;
                    nxtValue = accOut[15:0];
                end
            end
            StCsumLo: begin
                nxtState = StCsumHi;
                nxtValue = accOut[31:16];
            end
            StCsumHi, StPad: begin
                if (padCnt < cfgPadding) begin
                    nxtState  = StPad;
                    nxtPadCnt = padCnt + PadWidth'(1);
                end else begin
                    nxtState = StIdle;
                end
            end
            default: nxtState = StIdle;
        endcase
    end

    // Data words are folded into the checksum when loaded into the output register, so the
    // sums already cover the last pixel by the time the checksum word is selected.
    always_comb begin
        accEn  = advance && (nxtState == StHeader || nxtState == StPixels);
        accClr = startAccept || (handshake && nxtState == StIdle);
    end

    fletcher32_acc uAcc (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accClr),
        .en   (accEn),
        .din  (nxtValue),
        .dout (accOut)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            hdrIdx      <= '0;
            col         <= '0;
            row         <= '0;
            padCnt      <= '0;
            pixel       <= 16'h0000;
            cfgHdrCount <= '0;
            cfgWidth    <= '0;
            cfgHeight   <= '0;
            cfgPadding  <= '0;
            cfgInit     <= 16'h0000;
            cfgDelta    <= 16'h0000;
            outValid    <= 1'b0;
            outData     <= 16'h0000;
            doneQ       <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (startAccept) begin
                cfgHdrCount <= cfg_header_count;
                cfgWidth    <= cfg_width;
                cfgHeight   <= cfg_height;
                cfgPadding  <= cfg_padding;
                cfgInit     <= cfg_pixel_initial;
                cfgDelta    <= cfg_pixel_delta;
            end
            if (advance) begin
                state <= nxtState;
                col   <= nxtCol;
                row   <= nxtRow;
                pixel <= nxtPixel;
                if (nxtState == StIdle) begin
                    hdrIdx   <= '0;
                    padCnt   <= '0;
                    outValid <= 1'b0;
                    outData  <= 16'h0000;
                    doneQ    <= 1'b1;
                end else begin
                    hdrIdx   <= nxtHdrIdx;
                    padCnt   <= nxtPadCnt;
                    outValid <= 1'b1;
                    outData  <= byteSwap(nxtValue);
                end
            end
        end
    end

    assign hdr_idx   = hdrIdx;
    assign out_valid = outValid;
    assign out_data  = outData;
    assign busy      = (state != StIdle);
    assign done      = doneQ;

endmodule
